// File: rtl/axi_read_master.sv
// Single-burst AXI4 read master: accepts one command, issues one AR request,
// and forwards the R beats through a one-entry output register.
module axi_read_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  // command
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  // AR channel
  output logic [ADDRESS_WIDTH-1:0] araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  // R channel
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  // output stream
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  // status
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               dbg_state
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid && ready; a raised valid and its payload stay put until that edge.

  localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = {ADDRESS_WIDTH{1'b1}} << SIZE_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state;
  logic [8:0] beats_remaining;
  logic       err_flag;
  logic       last_held;   // output register holds the burst's final beat

  logic r_hs;
  logic out_hs;
  logic final_beat;
  logic early_last;

  assign r_hs       = rvalid && rready;
  assign out_hs     = out_valid && out_ready;
  assign final_beat = (beats_remaining == 9'd1);
  assign early_last = rlast && (beats_remaining > 9'd1);

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign arsize    = 3'(SIZE_LOG2);
  assign arburst   = 2'b01;
  assign dbg_state = state;
  // Once the final beat is captured no further beats are taken, even though
  // the output register may be draining in the same cycle.
  assign rready    = (state == S_DATA) && !last_held && (!out_valid || out_ready);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= S_IDLE;
      araddr          <= '0;
      arlen           <= '0;
      arvalid         <= 1'b0;
      beats_remaining <= '0;
      err_flag        <= 1'b0;
      last_held       <= 1'b0;
      out_data        <= '0;
      out_last        <= 1'b0;
      out_valid       <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;

      if (r_hs) begin
        out_data  <= rdata;
        out_last  <= final_beat || rlast;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            araddr          <= cmd_addr & ALIGN_MASK;
            arlen           <= cmd_len;
            arvalid         <= 1'b1;
            beats_remaining <= {1'b0, cmd_len} + 9'd1;
            state           <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_hs) begin
            beats_remaining <= (final_beat || early_last) ? 9'd0 : beats_remaining - 9'd1;
            if ((rresp != 2'b00) || early_last || (final_beat && !rlast))
              err_flag <= 1'b1;
            if (final_beat || rlast)
              last_held <= 1'b1;
          end
          if (last_held && out_hs) begin
            last_held <= 1'b0;
            done      <= 1'b1;
            error     <= err_flag;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          err_flag <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master: a bench-driven responder and sink,
// with every observation checked by an immediate assertion.
module tb_axi_read_master;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    dbg_state;

  int tests = 0;
  int fails = 0;
  int burst_id = 0;

  axi_read_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // One complete burst: command, AR phase (optionally stalled), R phase, done.
  task automatic run_burst(input logic [7:0] addr, input logic [7:0] len, input int ar_delay,
                           input int bad_beat, input int early_beats, input bit miss_last,
                           input bit toggle, input bit exp_err, input logic [7:0] exp_araddr);
    int nbeats, bi, got, cyc;
    bit prev_rhs, last_acc, finished;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] e;
    burst_id++;
    nbeats   = (early_beats > 0) ? early_beats : int'(len) + 1;
    bi = 0; got = 0; cyc = 0;
    prev_rhs = 0; last_acc = 0; finished = 0;

    chk("pre_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
    chk("ar_state", dbg_state, 1);
    chk("arlen", arlen, len);
    chk("arsize", arsize, 3'd2);
    chk("arburst", arburst, 2'b01);
    chk("busy_addr", busy, 1);

    // Stall AR while offering a stray command and a stray R beat.
    for (int i = 0; i < ar_delay; i++) begin
      cmd_valid = 1'b1; cmd_addr = 8'hFF; rvalid = 1'b1;
      #1;
      chk("ar_hold_valid", arvalid, 1);
      chk("ar_hold_addr", araddr, exp_araddr);
      chk("cmd_ready_addr", cmd_ready, 0);
      chk("rready_addr", rready, 0);
      tick();
    end
    cmd_valid = 1'b0; cmd_addr = addr; rvalid = 1'b0;
    arready = 1'b1;
    #1;
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, exp_araddr);
    tick();
    arready = 1'b0;
    chk("arvalid_drop", arvalid, 0);
    chk("data_state", dbg_state, 2);

    while (!finished && cyc < 300) begin
      rvalid    = (bi < nbeats);
      rdata     = 32'hD000_0000 + (burst_id << 8) + bi;
      rresp     = (bi == bad_beat) ? 2'b10 : 2'b00;
      rlast     = (bi == nbeats - 1) && !miss_last;
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (prev_rhs) chk("out_latency", out_valid, 1);
      if (last_acc) begin
        chk("done", done, 1);
        chk("error", error, exp_err);
        chk("beat_count", got, nbeats);
        finished = 1;
      end else begin
        chk("no_early_done", done, 0);
        if (out_valid && !out_ready) chk("rready_stall", rready, 0);
        if (!toggle && got > 0 && got < nbeats) chk("stream_gap", out_valid, 1);
        prev_rhs = rvalid && rready;
        if (prev_rhs) exp_q.push_back(rdata);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e);
            chk("out_last", out_last, (got == nbeats - 1));
            got++;
            if (got == nbeats) last_acc = 1;
          end
        end
      end
      if (!finished) begin
        tick();
        if (prev_rhs) bi++;
        cyc++;
      end
    end
    chk("burst_timeout", finished, 1);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; out_ready = 1'b1;
    tick();
    chk_idle("post_done");
    chk("error_cleared", error, 0);
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_error", error, 0);
    chk_idle("rst");
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;

    // Basic burst, unaligned address
    run_burst(8'h13, 8'd3, 0, -1, 0, 0, 0, 0, 8'h10);
    // Single beat with AR stalled 5 cycles
    run_burst(8'h2C, 8'd0, 5, -1, 0, 0, 0, 0, 8'h2C);
    // Backpressure on the output stream
    run_burst(8'h87, 8'd7, 0, -1, 0, 0, 1, 0, 8'h84);
    // SLVERR on beat 2, then a clean burst
    run_burst(8'h40, 8'd3, 2, 1, 0, 0, 0, 1, 8'h40);
    run_burst(8'h41, 8'd3, 0, -1, 0, 0, 0, 0, 8'h40);
    // Early rlast on beat 2
    run_burst(8'h50, 8'd3, 0, -1, 2, 0, 0, 1, 8'h50);
    // Missing rlast on the final beat
    run_burst(8'h60, 8'd1, 0, -1, 0, 1, 1, 1, 8'h60);

    // Reset in the middle of a 4-beat burst after 2 beats
    cmd_valid = 1'b1; cmd_addr = 8'h70; cmd_len = 8'd3;
    tick();
    cmd_valid = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'hBEEF_0000 + i; rresp = 2'b00; rlast = 1'b0;
      tick();
    end
    chk("mid_out_valid", out_valid, 1);
    aresetn = 1'b0;
    #1;
    chk("mr_arvalid", arvalid, 0);
    chk("mr_rready", rready, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_last", out_last, 0);
    chk("mr_error", error, 0);
    chk_idle("mr");
    rvalid = 1'b0;
    repeat (2) begin
      tick();
      chk("mr_no_done", done, 0);
    end
    aresetn = 1'b1;
    run_burst(8'h77, 8'd3, 0, -1, 0, 0, 0, 0, 8'h74);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
